// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode encoding and the
// width-generic extension function used at the pipe input.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_t;

    // Widest operand the function can produce; callers narrow the result with a cast.
    localparam int unsigned EXT_MAX_W = 128;

    // Extends the low in_w bits of imm to out_w bits; bits at and above out_w are zero.
    function automatic logic [EXT_MAX_W-1:0] ext_compute(
        input logic [EXT_MAX_W-1:0] imm,
        input ext_mode_t            mode,
        input int unsigned          in_w,
        input int unsigned          out_w
    );
        logic [EXT_MAX_W-1:0] field;
        logic [EXT_MAX_W-1:0] sext;
        logic [EXT_MAX_W-1:0] res;
        logic                 sign;
        field = '0;
        sext  = '0;
        res   = '0;
        sign  = 1'b0;
        for (int unsigned b = 0; b < EXT_MAX_W; b++) begin
            if (b == in_w - 1) sign = imm[b];
        end
        for (int unsigned b = 0; b < EXT_MAX_W; b++) begin
            field[b] = (b < in_w) ? imm[b] : 1'b0;
            sext[b]  = (b < in_w) ? imm[b] : sign;
        end
        case (mode)
            EXT_SIGN:   res = sext;
            EXT_ZERO:   res = field;
            EXT_UPPER:  res = field << (out_w - in_w);
            EXT_BRANCH: res = sext << 2;
            default:    res = '0;
        endcase
        for (int unsigned b = 0; b < EXT_MAX_W; b++) begin
            if (b >= out_w) res[b] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/imm_ext_stage.sv
// One valid/ready register slice. A bubble (v=0) is overwritten without
// waiting on downstream; a held entry stays put until downstream accepts it.
module imm_ext_stage #(
    parameter int unsigned W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         v;
    logic [W-1:0] d;

    // Slice can load whenever it is empty or its contents leave this cycle.
    always_comb begin
        up_ready = !v || dn_ready;
        dn_valid = v;
        dn_data  = d;
    end

    // Register the slice; data only changes when a valid entry is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= 1'b0;
            d <= '0;
        end else if (up_ready) begin
            v <= up_valid;
            if (up_valid) d <= up_data;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extension: the operand is extended combinationally at
// the input and then carried, together with its mode, through STAGES slices.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [1:0]       out_mode
);

    localparam int unsigned DW = OUT_W + 2;

    if (IN_W < 2 || OUT_W < IN_W + 2 || STAGES < 1 || OUT_W > EXT_MAX_W) begin : g_bad_params
        $error("imm_extend_pipe: illegal parameters IN_W=%0d OUT_W=%0d STAGES=%0d",
               IN_W, OUT_W, STAGES);
    end

    logic [OUT_W-1:0] ext_val;

    // Extend the incoming field for the selected mode.
    always_comb begin
        ext_val = OUT_W'(ext_compute(EXT_MAX_W'(in_imm), ext_mode_t'(in_mode), IN_W, OUT_W));
    end

    // Each slice's ready is looked up from the slice after it, so the chain is
    // wired by cross-referencing neighbouring generate iterations.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          up_v;
        logic          up_r;
        logic [DW-1:0] up_d;
        logic          dn_v;
        logic          dn_r;
        logic [DW-1:0] dn_d;

        if (k == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = {in_mode, ext_val};
        end else begin : g_link
            assign up_v = g_stage[k-1].dn_v;
            assign up_d = g_stage[k-1].dn_d;
        end

        if (k == STAGES - 1) begin : g_tail
            assign dn_r = out_ready;
        end else begin : g_mid
            assign dn_r = g_stage[k+1].up_r;
        end

        imm_ext_stage #(.W(DW)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (up_v),
            .up_ready (up_r),
            .up_data  (up_d),
            .dn_valid (dn_v),
            .dn_ready (dn_r),
            .dn_data  (dn_d)
        );
    end

    // Present the last slice; input is refused for the whole reset cycle.
    always_comb begin
        in_ready  = !reset && g_stage[0].up_r;
        out_valid = g_stage[STAGES-1].dn_v;
        out_mode  = g_stage[STAGES-1].dn_d[DW-1 -: 2];
        out_imm   = g_stage[STAGES-1].dn_d[OUT_W-1:0];
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: one build with STAGES=1 (index 0) and one with
// STAGES=3 (index 1), each followed by a queue scoreboard on its output.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_imm    [2];
    logic [1:0]  in_mode   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_imm   [2];
    logic [1:0]  out_mode  [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Reference extension from arithmetic on the integer value of the field.
    function automatic logic [31:0] ref_ext(logic [15:0] i, logic [1:0] m);
        longint s;
        longint v;
        s = (i >= 16'h8000) ? longint'(i) - 65536 : longint'(i);
        case (m)
            2'd0:    v = s;
            2'd1:    v = longint'(i);
            2'd2:    v = longint'(i) * 65536;
            default: v = s * 4;
        endcase
        return v[31:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int unsigned S = (d == 0) ? 1 : 3;

        imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(S)) u_dut (
            .clk       (clk),
            .reset     (rst[d]),
            .in_valid  (in_valid[d]),
            .in_ready  (in_ready[d]),
            .in_imm    (in_imm[d]),
            .in_mode   (in_mode[d]),
            .out_valid (out_valid[d]),
            .out_ready (out_ready[d]),
            .out_imm   (out_imm[d]),
            .out_mode  (out_mode[d])
        );

        logic [33:0] q[$];
        logic        stalled = 1'b0;
        logic [31:0] p_imm;
        logic [1:0]  p_mode;
        logic [33:0] e;

        // Scoreboard: in-order expected queue plus hold check while stalled.
        always @(negedge clk) begin
            if (rst[d]) begin
                q.delete();
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", 32'(out_valid[d]), 32'd1);
                    chk("stall_imm", out_imm[d], p_imm);
                    chk("stall_mode", 32'(out_mode[d]), 32'(p_mode));
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", out_imm[d], 32'hxxxxxxxx);
                    end else begin
                        e = q.pop_front();
                        chk("sb_imm", out_imm[d], e[31:0]);
                        chk("sb_mode", 32'(out_mode[d]), 32'(e[33:32]));
                    end
                end
                if (in_valid[d] && in_ready[d])
                    q.push_back({in_mode[d], ref_ext(in_imm[d], in_mode[d])});
                stalled = out_valid[d] && !out_ready[d];
                p_imm   = out_imm[d];
                p_mode  = out_mode[d];
            end
        end
    end

    function automatic int qsize(int d);
        return (d == 0) ? g_dut[0].q.size() : g_dut[1].q.size();
    endfunction

    // Offer one value into an empty pipe and measure accept-to-output latency.
    task automatic apply_vec(int d, logic [15:0] imm, logic [1:0] mode, logic [31:0] exp);
        int cnt;
        int s;
        s = (d == 0) ? 1 : 3;
        out_ready[d] = 1'b1;
        in_imm[d]    = imm;
        in_mode[d]   = mode;
        in_valid[d]  = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", 32'(in_ready[d]), 32'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        cnt = 1;
        while (cnt < 20) begin
            @(negedge clk);
            if (out_valid[d]) break;
            @(posedge clk); #1;
            cnt++;
        end
        chk("vec_latency", 32'(cnt), 32'(s));
        chk("vec_imm", out_imm[d], exp);
        chk("vec_mode", 32'(out_mode[d]), 32'(mode));
        @(posedge clk); #1;
    endtask

    task automatic drain(int d);
        int c;
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        c = 0;
        while (qsize(d) != 0 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        @(posedge clk); #1;
        chk("drain_empty", 32'(qsize(d)), 32'd0);
        chk("drain_no_valid", 32'(out_valid[d]), 32'd0);
    endtask

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl[8];
        logic [15:0] vals[5];
        int          idx;
        logic        acc;

        tbl[0] = '{16'h0004, 2'd0, 32'h00000004};
        tbl[1] = '{16'hFFFF, 2'd0, 32'hFFFFFFFF};
        tbl[2] = '{16'h8000, 2'd0, 32'hFFFF8000};
        tbl[3] = '{16'h7FFF, 2'd0, 32'h00007FFF};
        tbl[4] = '{16'h8000, 2'd1, 32'h00008000};
        tbl[5] = '{16'h1234, 2'd2, 32'h12340000};
        tbl[6] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
        tbl[7] = '{16'h7FFF, 2'd3, 32'h0001FFFC};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            in_imm[d] = '0; in_mode[d] = '0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("reset_in_ready_low", 32'(in_ready[d]), 32'd0);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
            chk("reset_out_imm", out_imm[d], 32'd0);
            chk("reset_out_mode", 32'(out_mode[d]), 32'd0);
            chk("reset_in_ready_high", 32'(in_ready[d]), 32'd1);
        end
        @(posedge clk); #1;

        // Directed mode table on both builds.
        for (int d = 0; d < 2; d++)
            for (int t = 0; t < 8; t++)
                apply_vec(d, tbl[t].imm, tbl[t].mode, tbl[t].exp);

        // Back-pressure on the 3-deep build: fill, stall, release.
        for (int k = 0; k < 5; k++) vals[k] = 16'($urandom);
        out_ready[1] = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid[1] = (idx < 5);
            in_imm[1]   = vals[idx < 5 ? idx : 4];
            in_mode[1]  = 2'(idx);
            @(negedge clk);
            acc = in_valid[1] && in_ready[1];
            @(posedge clk); #1;
            if (acc) idx++;
        end
        @(negedge clk);
        chk("bp_accepts", 32'(idx), 32'd3);
        chk("bp_in_ready_low", 32'(in_ready[1]), 32'd0);
        chk("bp_head_imm", out_imm[1], ref_ext(vals[0], 2'd0));
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid[1] = (idx < 5);
            in_imm[1]   = vals[idx < 5 ? idx : 4];
            in_mode[1]  = 2'(idx);
            @(negedge clk);
            chk("bp_no_gap", 32'(out_valid[1]), 32'd1);
            acc = in_valid[1] && in_ready[1];
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd5);
        drain(1);

        // Full-rate streaming.
        for (int d = 0; d < 2; d++) begin
            out_ready[d] = 1'b1;
            for (int c = 0; c < 100; c++) begin
                in_valid[d] = 1'b1;
                in_imm[d]   = 16'($urandom);
                in_mode[d]  = 2'($urandom);
                @(negedge clk);
                chk("stream_in_ready", 32'(in_ready[d]), 32'd1);
                if (c >= ((d == 0) ? 1 : 3))
                    chk("stream_out_valid", 32'(out_valid[d]), 32'd1);
                @(posedge clk); #1;
            end
            drain(d);
        end

        // Random valid/ready toggling.
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 1000; c++) begin
                in_valid[d]  = 1'($urandom_range(0, 1));
                out_ready[d] = 1'($urandom_range(0, 1));
                in_imm[d]    = 16'($urandom);
                in_mode[d]   = 2'($urandom);
                @(posedge clk); #1;
            end
            drain(d);
        end

        // Reset with two entries in flight on the 3-deep build.
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_imm[1]  = 16'hA5A0 + 16'(c);
            in_mode[1] = 2'd1;
            @(posedge clk); #1;
        end
        in_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_low", 32'(in_ready[1]), 32'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid[1]), 32'd0);
        chk("midrst_out_imm", out_imm[1], 32'd0);
        chk("midrst_in_ready_high", 32'(in_ready[1]), 32'd1);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("midrst_no_old", 32'(out_valid[1]), 32'd0);
            @(posedge clk); #1;
        end
        apply_vec(1, 16'h8001, 2'd3, 32'hFFFE0004);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
